// File: rtl/accel_csr_pkg.sv
// Shared CSR offsets, status bit positions and FSM state type for the accelerator CSR responder.
package accel_csr_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OFF_W    = 5;
  localparam int unsigned STATUS_W = 4;

  // Byte offsets inside the 32-byte CSR window
  localparam logic [OFF_W-1:0] CSR_CTRL   = 5'h00;
  localparam logic [OFF_W-1:0] CSR_STATUS = 5'h04;
  localparam logic [OFF_W-1:0] CSR_X      = 5'h08;
  localparam logic [OFF_W-1:0] CSR_Y      = 5'h0C;
  localparam logic [OFF_W-1:0] CSR_CYCLES = 5'h10;

  // CTRL write bits
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLR   = 1;

  // STATUS read bits
  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_ERR  = 2;
  localparam int unsigned ST_OVR  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/accel_csr_regfile.sv
// Bus-facing half of the responder: window decode, Y_OUT stall, X_IN byte writes, read mux, resp register.
module accel_csr_regfile
  import accel_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h80001000,
  parameter int unsigned WAIT_ON_BUSY = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                bus_req_i,
  input  logic                bus_we_i,
  input  logic [31:0]         bus_addr_bi,
  input  logic [3:0]          bus_be_bi,
  input  logic [31:0]         bus_wdata_bi,
  output logic                bus_ack_o,
  output logic                bus_resp_o,
  output logic [31:0]         bus_rdata_bo,
  input  logic [STATUS_W-1:0] status,
  input  logic [DATA_W-1:0]   y_out,
  input  logic [DATA_W-1:0]   cycles,
  output logic                start_wr_c,
  output logic                clr_wr_c,
  output logic [DATA_W-1:0]   x_in
);

  logic             hit_c;
  logic             stall_c;
  logic             wr_c;
  logic             rd_c;
  logic [OFF_W-1:0] off_c;
  logic [DATA_W-1:0] rd_mux_c;
  logic [1:0]       unused_addr_lsb;

  // Byte lane bits of the address carry no meaning for word-wide CSRs
  assign unused_addr_lsb = bus_addr_bi[1:0];

  // Window is 32-byte aligned, so a hit is a match on the upper address bits
  assign hit_c   = bus_req_i && (bus_addr_bi[31:OFF_W] == BASE_ADDR[31:OFF_W]);
  assign off_c   = {bus_addr_bi[OFF_W-1:2], 2'b00};
  assign stall_c = hit_c && !bus_we_i && (off_c == CSR_Y) && status[ST_BUSY]
                   && (WAIT_ON_BUSY != 0);

  assign bus_ack_o  = hit_c && !stall_c;
  assign wr_c       = bus_ack_o && bus_we_i;
  assign rd_c       = bus_ack_o && !bus_we_i;
  assign start_wr_c = wr_c && (off_c == CSR_CTRL) && bus_wdata_bi[CTRL_START];
  assign clr_wr_c   = wr_c && (off_c == CSR_CTRL) && bus_wdata_bi[CTRL_CLR];

  // Read data selection; CTRL and the reserved words read as zero
  always_comb begin
    rd_mux_c = '0;
    case (off_c)
      CSR_STATUS: rd_mux_c = DATA_W'(status);
      CSR_X:      rd_mux_c = x_in;
      CSR_Y:      rd_mux_c = y_out;
      CSR_CYCLES: rd_mux_c = cycles;
      default:    rd_mux_c = '0;
    endcase
  end

  // X_IN operand register with per-lane byte enables
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      x_in <= '0;
    end else if (wr_c && (off_c == CSR_X)) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_be_bi[i]) x_in[8*i +: 8] <= bus_wdata_bi[8*i +: 8];
      end
    end
  end

  // Response one cycle after an accepted read; data forced to zero otherwise
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      bus_resp_o   <= 1'b0;
      bus_rdata_bo <= '0;
    end else begin
      bus_resp_o   <= rd_c;
      bus_rdata_bo <= rd_c ? rd_mux_c : '0;
    end
  end

endmodule

// File: rtl/accel_csr_responder.sv
// CSR slave that launches a multi-cycle accelerator, tracks status and measures op latency.
module accel_csr_responder
  import accel_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h80001000,
  parameter int unsigned ACC_TIMEOUT  = 1024,
  parameter int unsigned WAIT_ON_BUSY = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        acc_start_o,
  output logic [31:0] acc_x_o,
  input  logic        acc_done_i,
  input  logic [31:0] acc_y_i
);

  // Last counter value still allowed in RUN; reaching ACC_TIMEOUT aborts the op
  localparam logic [DATA_W-1:0] TIMEOUT_LAST = DATA_W'(ACC_TIMEOUT - 1);

  acc_state_t        state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_x_d;
  logic              acc_start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] cycles_q, cycles_d;

  logic [STATUS_W-1:0] status_c;
  logic                start_wr_c;
  logic                clr_wr_c;
  logic [DATA_W-1:0]   x_in;

  accel_csr_regfile #(
    .BASE_ADDR   (BASE_ADDR),
    .WAIT_ON_BUSY(WAIT_ON_BUSY)
  ) u_regfile (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .bus_req_i   (bus_req_i),
    .bus_we_i    (bus_we_i),
    .bus_addr_bi (bus_addr_bi),
    .bus_be_bi   (bus_be_bi),
    .bus_wdata_bi(bus_wdata_bi),
    .bus_ack_o   (bus_ack_o),
    .bus_resp_o  (bus_resp_o),
    .bus_rdata_bo(bus_rdata_bo),
    .status      (status_c),
    .y_out       (y_q),
    .cycles      (cycles_q),
    .start_wr_c  (start_wr_c),
    .clr_wr_c    (clr_wr_c),
    .x_in        (x_in)
  );

  // STATUS word assembly
  always_comb begin
    status_c          = '0;
    status_c[ST_BUSY] = (state_q == RUN);
    status_c[ST_DONE] = done_q;
    status_c[ST_ERR]  = err_q;
    status_c[ST_OVR]  = ovr_q;
  end

  // Launch/run/timeout next-state logic; CLR acts before START or completion in the same cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_x_d     = acc_x_o;
    acc_start_d = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
    y_d         = y_q;
    cycles_d    = cycles_q;

    if (clr_wr_c) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_wr_c) begin
          state_d     = RUN;
          acc_x_d     = x_in;
          acc_start_d = 1'b1;
          cnt_d       = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
        end
      end
      RUN: begin
        if (start_wr_c) ovr_d = 1'b1;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + DATA_W'(1);
        if (acc_done_i) begin
          y_d      = acc_y_i;
          cycles_d = cnt_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_x_o     <= '0;
      acc_start_o <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      y_q         <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_x_o     <= acc_x_d;
      acc_start_o <= acc_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      y_q         <= y_d;
      cycles_q    <= cycles_d;
    end
  end

endmodule

// File: tb/tb_accel_csr_responder.sv
// Directed bench for accel_csr_responder with a delay-programmable accelerator stub.
module tb_accel_csr_responder;

  localparam logic [31:0] BASE = 32'h80001000;

  logic        clk_gen;
  logic        srst;        // active-low
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;
  logic        acc_start_o;
  logic [31:0] acc_x_o;
  logic        acc_done;
  logic [31:0] acc_y;

  int          n_chk  = 0;
  int          n_pass = 0;

  // stub control/observation
  int          stub_delay  = -1;
  logic [31:0] stub_y      = '0;
  logic        manual_done = 1'b0;
  int          left        = 0;
  int          n_starts    = 0;
  logic [31:0] x_seen      = '0;

  accel_csr_responder #(
    .BASE_ADDR   (BASE),
    .ACC_TIMEOUT (16),
    .WAIT_ON_BUSY(1)
  ) dut (
    .clk_i       (clk_gen),
    .rstn_i      (srst),
    .bus_req_i   (bus_req),
    .bus_we_i    (bus_we),
    .bus_addr_bi (bus_addr),
    .bus_be_bi   (bus_be),
    .bus_wdata_bi(bus_wdata),
    .bus_ack_o   (bus_ack_o),
    .bus_resp_o  (bus_resp_o),
    .bus_rdata_bo(bus_rdata_bo),
    .acc_start_o (acc_start_o),
    .acc_x_o     (acc_x_o),
    .acc_done_i  (acc_done),
    .acc_y_i     (acc_y)
  );

  initial clk_gen = 1'b0;
  always #5 clk_gen = ~clk_gen;

  // Accelerator stub: answers stub_delay cycles after the start pulse (negative = never)
  initial begin
    acc_done = 1'b0;
    acc_y    = '0;
    forever begin
      @(posedge clk_gen);
      #2;
      acc_done = manual_done;
      if (acc_start_o) begin
        n_starts = n_starts + 1;
        x_seen   = acc_x_o;
        left     = stub_delay;
      end else if (left > 0) begin
        left = left - 1;
        if (left == 0) acc_done = 1'b1;
      end
      acc_y = acc_done ? stub_y : 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_gen);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    bus_be    = be;
    tick();
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_be    = 4'h0;
    bus_wdata = '0;
  endtask

  // Issues a read, waits (bounded) for ack, returns data from the resp cycle
  task automatic bus_read(input string tag, input logic [31:0] addr,
                          output logic [31:0] data, output int waited);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = addr;
    waited   = 0;
    data     = '0;
    #1;
    while (!bus_ack_o && waited < 40) begin
      tick();
      waited = waited + 1;
    end
    if (!bus_ack_o) begin
      chk({tag, " ack_timeout"}, 32'(bus_ack_o), 32'd1);
      bus_req = 1'b0;
    end else begin
      tick();
      bus_req = 1'b0;
      chk({tag, " resp"}, 32'(bus_resp_o), 32'd1);
      data = bus_rdata_bo;
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    bus_read(tag, addr, d, w);
    chk(tag, d, exp);
  endtask

  initial begin : main
    logic [31:0] d;
    int w;
    srst      = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'h0;
    bus_wdata = '0;
    repeat (3) tick();
    chk("rst acc_x", acc_x_o, 32'h0);
    chk("rst acc_start", 32'(acc_start_o), 32'h0);
    chk("rst resp", 32'(bus_resp_o), 32'h0);
    srst = 1'b1;
    tick();

    // 1: idle register reads, resp lasts exactly one cycle
    bus_read("t1 status", BASE + 32'h04, d, w);
    chk("t1 status", d, 32'h0);
    tick();
    chk("t1 resp_one_cycle", 32'(bus_resp_o), 32'h0);
    rd_chk("t1 ctrl", BASE + 32'h00, 32'h0);
    rd_chk("t1 x_in", BASE + 32'h08, 32'h0);
    rd_chk("t1 y_out", BASE + 32'h0C, 32'h0);
    chk("t1 no_start", 32'(n_starts), 32'd0);

    // 2: byte-enabled X_IN write, then a 10-cycle op
    bus_write(BASE + 32'h08, 32'hDEAD4000, 4'b0011);
    rd_chk("t2 x_in_be", BASE + 32'h08, 32'h00004000);
    stub_delay = 10;
    stub_y     = 32'h12345678;
    bus_write(BASE + 32'h00, 32'h1, 4'hF);
    repeat (12) tick();
    chk("t2 starts", 32'(n_starts), 32'd1);
    chk("t2 x_seen", x_seen, 32'h00004000);
    rd_chk("t2 status", BASE + 32'h04, 32'h2);
    rd_chk("t2 y_out", BASE + 32'h0C, 32'h12345678);
    rd_chk("t2 cycles", BASE + 32'h10, 32'd10);

    // 3: Y_OUT read stalls while busy; done at start+12, accepted the cycle after
    stub_delay = 12;
    stub_y     = 32'hCAFEF00D;
    bus_write(BASE + 32'h00, 32'h1, 4'hF);
    tick();
    bus_read("t3 y_stall", BASE + 32'h0C, d, w);
    chk("t3 stall_cycles", 32'(w), 32'd12);
    chk("t3 y_new", d, 32'hCAFEF00D);
    rd_chk("t3 cycles", BASE + 32'h10, 32'd12);

    // 4: accelerator never answers, timeout after 16 cycles in RUN
    stub_delay = -1;
    bus_write(BASE + 32'h00, 32'h1, 4'hF);
    repeat (15) tick();
    rd_chk("t4 status_last_run", BASE + 32'h04, 32'h1);
    rd_chk("t4 status_err", BASE + 32'h04, 32'h4);
    rd_chk("t4 y_kept", BASE + 32'h0C, 32'hCAFEF00D);
    bus_write(BASE + 32'h00, 32'h2, 4'hF);
    rd_chk("t4 status_clr", BASE + 32'h04, 32'h0);

    // 5: second START while busy sets OVR; X_IN write mid-run leaves acc_x_o alone
    stub_delay = 8;
    stub_y     = 32'h0BADBEEF;
    bus_write(BASE + 32'h00, 32'h1, 4'hF);
    bus_write(BASE + 32'h08, 32'h11112222, 4'hF);
    bus_write(BASE + 32'h00, 32'h1, 4'hF);
    rd_chk("t5 status_busy_ovr", BASE + 32'h04, 32'h9);
    chk("t5 acc_x_stable", acc_x_o, 32'h00004000);
    repeat (8) tick();
    chk("t5 starts", 32'(n_starts), 32'd4);
    rd_chk("t5 status", BASE + 32'h04, 32'hA);
    rd_chk("t5 y_out", BASE + 32'h0C, 32'h0BADBEEF);
    rd_chk("t5 cycles", BASE + 32'h10, 32'd8);
    rd_chk("t5 x_in", BASE + 32'h08, 32'h11112222);

    // 6: outside-window accesses, reserved word, reset mid-run
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 32'h80000000;
    #1;
    chk("t6 out_ack", 32'(bus_ack_o), 32'h0);
    tick();
    bus_addr = BASE + 32'h20;
    #1;
    chk("t6 past_end_ack", 32'(bus_ack_o), 32'h0);
    tick();
    bus_req = 1'b0;
    chk("t6 out_resp", 32'(bus_resp_o), 32'h0);
    chk("t6 out_rdata", bus_rdata_bo, 32'h0);
    bus_write(32'h80000008, 32'hFFFFFFFF, 4'hF);
    rd_chk("t6 x_untouched", BASE + 32'h08, 32'h11112222);
    rd_chk("t6 reserved", BASE + 32'h14, 32'h0);

    stub_delay = -1;
    stub_y     = 32'h55555555;
    bus_write(BASE + 32'h00, 32'h3, 4'hF);
    repeat (3) tick();
    srst = 1'b0;
    repeat (2) tick();
    srst = 1'b1;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    tick();
    rd_chk("t6 status_after_rst", BASE + 32'h04, 32'h0);
    rd_chk("t6 y_after_rst", BASE + 32'h0C, 32'h0);
    rd_chk("t6 cycles_after_rst", BASE + 32'h10, 32'h0);
    chk("t6 acc_x_after_rst", acc_x_o, 32'h0);
    chk("t6 starts", 32'(n_starts), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
